// File: rtl/video_timing_if.sv
// video_timing_if: raster timing bundle from the timing generator to the pixel pipeline
// o_hsync/o_vsync     : sync pulses at their configured polarity
// o_data_en           : active-video qualifier
// o_xpos/o_ypos       : signed raster coordinates, active video starts at (0,0)
// o_line_start        : pulse on the first slot of every line
// o_frame_start       : pulse on the first slot of every frame
// o_frame             : 9-bit frame counter
// master: timing generator, slave: pixel generator / encoder
interface video_timing_if;
    logic               o_hsync;
    logic               o_vsync;
    logic               o_data_en;
    logic signed [15:0] o_xpos;
    logic signed [15:0] o_ypos;
    logic               o_line_start;
    logic               o_frame_start;
    logic [8:0]         o_frame;
    modport master (
        output o_hsync, o_vsync, o_data_en, o_xpos, o_ypos,
               o_line_start, o_frame_start, o_frame
    );
    modport slave (
        input  o_hsync, o_vsync, o_data_en, o_xpos, o_ypos,
               o_line_start, o_frame_start, o_frame
    );
endinterface

// File: rtl/video_timing.sv
// video_timing: free-running raster timing generator with signed pixel coordinates
// clk   : pixel clock
// reset : synchronous active-high reset, parks the raster at frame origin
// vif   : video_timing_if master, all outputs registered and aligned to xpos/ypos
module video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    video_timing_if.master vif
);
    localparam int HB = H_FP + H_SYNC + H_BP;
    localparam int VB = V_FP + V_SYNC + V_BP;
    localparam logic signed [15:0] X_MIN  = 16'(-HB);
    localparam logic signed [15:0] X_MAX  = 16'(H_ACTIVE - 1);
    localparam logic signed [15:0] Y_MIN  = 16'(-VB);
    localparam logic signed [15:0] Y_MAX  = 16'(V_ACTIVE - 1);
    localparam logic signed [15:0] HS_BEG = 16'(H_FP - HB);
    localparam logic signed [15:0] HS_END = 16'(-H_BP - 1);
    localparam logic signed [15:0] VS_BEG = 16'(V_FP - VB);
    localparam logic signed [15:0] VS_END = 16'(-V_BP - 1);

    if (HB + H_ACTIVE > 32767 || VB + V_ACTIVE > 32767) begin : g_chk_width
        $error("video_timing: raster geometry does not fit in 15 bits");
    end
    // Blanking must be a whole number of 8-pixel cells so fetch phases line up with xpos = 0
    if (HB % 8 != 0) begin : g_chk_hb
        $error("video_timing: H_FP+H_SYNC+H_BP must be a multiple of 8");
    end

    logic signed [15:0] r_x;
    logic signed [15:0] r_y;
    logic signed [15:0] w_nx;
    logic signed [15:0] w_ny;
    logic [8:0]         r_frame;
    logic               r_run;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;
    logic               r_ls;
    logic               r_fs;
    logic               w_x_last;
    logic               w_y_last;

    // r_run holds the raster at origin for the first cycle after reset so that
    // cycle carries the line/frame start pulses; outputs come from the next coordinates
    always_comb begin
        w_x_last = r_x == X_MAX;
        w_y_last = r_y == Y_MAX;
        w_nx     = (!r_run || w_x_last) ? X_MIN : r_x + 16'sd1;
        w_ny     = !r_run ? Y_MIN : !w_x_last ? r_y : w_y_last ? Y_MIN : r_y + 16'sd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run   <= 1'b0;
            r_x     <= X_MIN;
            r_y     <= Y_MIN;
            r_frame <= '0;
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_frame <= r_frame + {8'd0, r_run && w_x_last && w_y_last};
            r_hsync <= (w_nx >= HS_BEG && w_nx <= HS_END) ? H_POL : ~H_POL;
            r_vsync <= (w_ny >= VS_BEG && w_ny <= VS_END) ? V_POL : ~V_POL;
            r_de    <= w_nx >= 16'sd0 && w_ny >= 16'sd0;
            r_ls    <= w_nx == X_MIN;
            r_fs    <= w_nx == X_MIN && w_ny == Y_MIN;
        end
    end

    assign vif.o_xpos        = r_x;
    assign vif.o_ypos        = r_y;
    assign vif.o_frame       = r_frame;
    assign vif.o_hsync       = r_hsync;
    assign vif.o_vsync       = r_vsync;
    assign vif.o_data_en     = r_de;
    assign vif.o_line_start  = r_ls;
    assign vif.o_frame_start = r_fs;
endmodule
